// File: rtl/bcd_convert_scheduler_pkg.sv
// bcd_convert_scheduler_pkg: shared FSM encoding, BCD adjust threshold and digit adjust helper.
package bcd_convert_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ADJ = 4'd5;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= BCD_ADJ) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// bcd_convert_scheduler_if: requester-side bus of the shared BCD converter.
//   req/operand  : per-requester level request and packed operands (master drives)
//   ack/valid    : one-cycle completion pulses (slave drives)
//   busy/owner   : engine activity and current/last served requester
//   hundred/ten/one/negative : held result of the last conversion
interface bcd_convert_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int BITS    = 10,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*BITS-1:0] operand;
    logic [NUM_REQ-1:0]      ack;
    logic                    busy;
    logic [ID_W-1:0]         owner;
    logic [3:0]              hundred;
    logic [3:0]              ten;
    logic [3:0]              one;
    logic                    negative;
    logic                    valid;

    modport master (
        output req, operand,
        input  ack, busy, owner, hundred, ten, one, negative, valid
    );

    modport slave (
        input  req, operand,
        output ack, busy, owner, hundred, ten, one, negative, valid
    );
endinterface

// File: rtl/bcd_convert_scheduler_rr_arbiter.sv
// bcd_convert_scheduler_rr_arbiter: combinational round-robin pick, first set request at or above i_ptr.
//   i_req   : request vector
//   i_ptr   : highest-priority index (always < NUM_REQ)
//   o_grant : winning index
//   o_any   : at least one request pending
module bcd_convert_scheduler_rr_arbiter
    import bcd_convert_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_grant,
    output logic               o_any
);
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotating a doubled copy puts req[i_ptr] at bit 0, so the lowest set bit is the winner.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_ptr);
    assign o_any = |w_rot;

    always_comb begin
        o_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i])
                o_grant = ID_W'((int'(i_ptr) + i >= NUM_REQ) ? int'(i_ptr) + i - NUM_REQ : int'(i_ptr) + i);
    end
endmodule

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: one shift-add-3 binary-to-BCD engine shared round-robin between requesters.
//   clock/reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : req/operand in; ack/valid pulses, busy, owner and held sign+BCD result out
module bcd_convert_scheduler
    import bcd_convert_scheduler_pkg::*;
#(
    parameter int BITS    = 10,
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input logic                   clock,
    input logic                   reset_n,
    bcd_convert_scheduler_if.slave bus
);
    localparam int CW = $clog2(BITS);

    state_t             r_state;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_ptr;
    logic [BITS-1:0]    r_mag;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_hun, r_ten, r_one;
    logic               r_neg_int;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;
    logic               r_valid;
    logic               r_neg;
    logic [3:0]         r_out_hun, r_out_ten, r_out_one;

    logic [ID_W-1:0]    w_grant;
    logic               w_any;
    logic [BITS-1:0]    w_op;
    logic [11:0]        w_shift;

    bcd_convert_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_comb begin
        w_op = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (r_owner == ID_W'(k))
                w_op = bus.operand[k*BITS +: BITS];
    end

    // Adjust every digit, then shift the next magnitude bit in; the digit top bit falls off (value < 1000).
    assign w_shift = 12'({add3(r_hun), add3(r_ten), add3(r_one), r_mag[r_cnt]});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_hun     <= '0;
            r_ten     <= '0;
            r_one     <= '0;
            r_neg_int <= 1'b0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_neg     <= 1'b0;
            r_out_hun <= '0;
            r_out_ten <= '0;
            r_out_one <= '0;
        end else begin
            r_valid <= 1'b0;
            r_ack   <= '0;
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_owner <= w_grant;
                    r_busy  <= 1'b1;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_mag     <= w_op[BITS-1] ? ~(w_op - 1'b1) : w_op;
                    r_neg_int <= w_op[BITS-1];
                    r_hun     <= '0;
                    r_ten     <= '0;
                    r_one     <= '0;
                    r_cnt     <= CW'(BITS - 1);
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {r_hun, r_ten, r_one} <= w_shift;
                    if (r_cnt == '0) begin
                        // Outputs and pulses are registered on the entry edge so they are visible during DONE.
                        {r_out_hun, r_out_ten, r_out_one} <= w_shift;
                        r_neg   <= r_neg_int;
                        r_valid <= 1'b1;
                        r_ack   <= NUM_REQ'(1) << r_owner;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;
    assign bus.hundred  = r_out_hun;
    assign bus.ten      = r_out_ten;
    assign bus.one      = r_out_one;
    assign bus.negative = r_neg;
    assign bus.valid    = r_valid;
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: randomized and directed checks of the shared BCD converter against an arithmetic model.
module tb_bcd_convert_scheduler;
    localparam int N = 3;
    localparam int B = 10;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    bcd_convert_scheduler_if #(.NUM_REQ(N), .BITS(B), .ID_W(W)) bus();

    bcd_convert_scheduler #(.BITS(B), .NUM_REQ(N), .ID_W(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {negative, hundreds, tens, ones} from the signed value by plain arithmetic.
    function automatic logic [12:0] model(input logic [9:0] op);
        int v, m;
        v = op[9] ? int'(op) - 1024 : int'(op);
        m = (v < 0) ? -v : v;
        return {(v < 0) ? 1'b1 : 1'b0, 4'(m / 100), 4'(m / 10 % 10), 4'(m % 10)};
    endfunction

    function automatic logic [12:0] result();
        return {bus.negative, bus.hundred, bus.ten, bus.one};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.operand = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, want 0", bus.busy, n);
        end
    endtask

    task automatic convert(input int k, input logic [9:0] op, input string name);
        logic [12:0] e;
        int cyc = 0;
        bit got = 0;
        wait_idle();
        e = model(op);
        bus.operand[k*B +: B] = op;
        bus.req[k] = 1'b1;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.valid;
        end
        bus.req[k] = 1'b0;
        total++;
        if (!got || cyc !== 12) begin
            bad++;
            $display("FAIL %s latency: got=%0b cycles=%0d, want valid at 12", name, got, cyc);
        end
        total++;
        if (bus.ack !== N'(1 << k)) begin
            bad++;
            $display("FAIL %s ack: got %b, want %b", name, bus.ack, N'(1 << k));
        end
        total++;
        if (bus.owner !== W'(k)) begin
            bad++;
            $display("FAIL %s owner: got %0d, want %0d", name, bus.owner, k);
        end
        total++;
        if (result() !== e) begin
            bad++;
            $display("FAIL %s digits (op=%h): got neg=%0b %0d/%0d/%0d, want neg=%0b %0d/%0d/%0d",
                     name, op, result()[12], result()[11:8], result()[7:4], result()[3:0],
                     e[12], e[11:8], e[7:4], e[3:0]);
        end
        model_ptr = (k + 1) % N;
        @(posedge clk);
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.ack !== '0) begin
            bad++;
            $display("FAIL %s pulse_width: valid=%0b ack=%b one cycle later, want 0/000", name, bus.valid, bus.ack);
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        do_reset();
        @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.valid, bus.ack, bus.owner} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%0b valid=%0b ack=%b owner=%0d, want all 0",
                     bus.busy, bus.valid, bus.ack, bus.owner);
        end
        total++;
        if (result() !== '0) begin
            bad++;
            $display("FAIL reset_digits: got %h, want 0", result());
        end
        convert(0, 10'd255, "pre_reset");
        wait_idle();
        bus.operand[2*B +: B] = 10'd300;
        bus.req[2] = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.valid, bus.ack, bus.owner} !== '0) begin
            bad++;
            $display("FAIL midreset_ctrl: busy=%0b valid=%0b ack=%b owner=%0d, want all 0",
                     bus.busy, bus.valid, bus.ack, bus.owner);
        end
        total++;
        if (result() !== '0) begin
            bad++;
            $display("FAIL midreset_digits: got %h, want 0", result());
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.ack !== '0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_noack: got %0d ack/valid cycles, want 0", seen);
        end
        convert(0, 10'd123, "after_reset");
    endtask

    task automatic test_single();
        convert(0, 10'd255, "single_255");
    endtask

    task automatic test_signed();
        convert(1, 10'h3FF, "minus_one");
        convert(2, 10'h200, "most_negative");
        convert(0, 10'd0, "zero");
        convert(1, 10'd511, "max_positive");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            convert(int'($urandom_range(0, N - 1)), 10'($urandom_range(0, 1023)), "random");
    endtask

    task automatic test_fairness();
        logic [9:0] ops[N];
        int cyc = 0;
        int exp_own;
        bit got;
        do_reset();
        wait_idle();
        for (int k = 0; k < N; k++) begin
            ops[k] = 10'($urandom_range(0, 1023));
            bus.operand[k*B +: B] = ops[k];
        end
        bus.req = '1;
        for (int g = 0; g < 6; g++) begin
            exp_own = model_ptr;
            got = 0;
            while (!got && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
                got = bus.valid;
            end
            if (g == 5) bus.req = '0;
            total++;
            if (!got || cyc !== ((g == 0) ? 12 : 13)) begin
                bad++;
                $display("FAIL fair_gap%0d: got=%0b cycles=%0d, want %0d", g, got, cyc, (g == 0) ? 12 : 13);
            end
            total++;
            if (bus.owner !== W'(exp_own) || bus.ack !== N'(1 << exp_own)) begin
                bad++;
                $display("FAIL fair_owner%0d: owner=%0d ack=%b, want %0d", g, bus.owner, bus.ack, exp_own);
            end
            total++;
            if (result() !== model(ops[exp_own])) begin
                bad++;
                $display("FAIL fair_digits%0d: got %h, want %h", g, result(), model(ops[exp_own]));
            end
            model_ptr = (exp_own + 1) % N;
            @(posedge clk);
            #1;
            cyc = 1;
            total++;
            if (bus.ack !== '0 || bus.valid !== 1'b0) begin
                bad++;
                $display("FAIL fair_width%0d: ack=%b valid=%0b, want 000/0", g, bus.ack, bus.valid);
            end
        end
    endtask

    task automatic test_operand_stability();
        int cyc = 0;
        bit got = 0;
        wait_idle();
        bus.operand[B +: B] = 10'd100;
        bus.req[1] = 1'b1;
        repeat (5) @(posedge clk);
        cyc = 5;
        #1;
        bus.operand[B +: B] = 10'd7;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.valid;
        end
        bus.req[1] = 1'b0;
        total++;
        if (!got || cyc !== 12 || result() !== model(10'd100)) begin
            bad++;
            $display("FAIL operand_stable: got=%0b cycles=%0d digits=%h, want 12 and %h", got, cyc, result(), model(10'd100));
        end
        model_ptr = 2;
    endtask

    task automatic test_withdraw();
        logic [9:0] o0, o2;
        logic [12:0] r1;
        int cyc = 0;
        int held_bad = 0;
        bit got = 0;
        do_reset();
        wait_idle();
        o0 = 10'($urandom_range(0, 1023));
        o2 = 10'($urandom_range(0, 1023));
        bus.operand[0 +: B] = o0;
        bus.operand[2*B +: B] = o2;
        bus.req = 3'b101;
        repeat (5) @(posedge clk);
        cyc = 5;
        #1;
        bus.req[0] = 1'b0;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.valid;
        end
        total++;
        if (!got || cyc !== 12 || bus.ack !== 3'b001 || result() !== model(o0)) begin
            bad++;
            $display("FAIL withdraw_first: got=%0b cycles=%0d ack=%b digits=%h, want 12 001 %h",
                     got, cyc, bus.ack, result(), model(o0));
        end
        r1 = model(o0);
        cyc = 0;
        got = 0;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.valid;
            if (!got && result() !== r1) held_bad++;
        end
        bus.req = '0;
        total++;
        if (held_bad !== 0) begin
            bad++;
            $display("FAIL withdraw_hold: %0d cycles showed digits other than %h", held_bad, r1);
        end
        total++;
        if (!got || cyc !== 13 || bus.owner !== 2'd2 || bus.ack !== 3'b100 || result() !== model(o2)) begin
            bad++;
            $display("FAIL withdraw_next: got=%0b cycles=%0d owner=%0d ack=%b digits=%h, want 13 2 100 %h",
                     got, cyc, bus.owner, bus.ack, result(), model(o2));
        end
    endtask

    initial begin
        bus.req = '0;
        bus.operand = '0;
        test_reset();
        test_single();
        test_signed();
        test_random();
        test_fairness();
        test_operand_stability();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
